bist_march_gen: RTL and testbench

- March C- sequencer that drives the RAM under test during MBIST.
- Sits directly upstream of bist_comparator:
  - generates RAM address, write enable, read enable and write data;
  - presents expected data on data_t, aligned with the RAM's read data (ramout);
  - consumes the comparator's eq result to record pass/fail and the first failing location.

---
 rtl/bist_pkg.sv | 36 +++
 rtl/bist_rd_pipe.sv | 52 +++++
 rtl/bist_march_gen.sv | 165 ++++++++++++++++
 tb/tb_bist_march_gen.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/bist_pkg.sv
// Shared types, constants and March C- element tables for the MBIST sequencer.
package bist_pkg;

  typedef enum logic [3:0] {
    StIdle  = 4'd0,
    StM0    = 4'd1,
    StM1    = 4'd2,
    StM2    = 4'd3,
    StM3    = 4'd4,
    StM4    = 4'd5,
    StM5    = 4'd6,
    StDrain = 4'd7,
    StDone  = 4'd8
  } march_state_t;

  localparam int unsigned MARCH_ELEMS = 6;
  localparam int unsigned ELEM_W      = 3;
  localparam int unsigned MAX_DATA_W  = 64;

  // Per-element tables indexed by element number; bits 6/7 are padding so a
  // 3-bit index is always in range.
  localparam logic [7:0] ELEM_DOWN   = 8'b0001_1000;  // M3, M4 walk D-1..0
  localparam logic [7:0] ELEM_HAS_RD = 8'b0011_1110;  // M1..M5 read
  localparam logic [7:0] ELEM_HAS_WR = 8'b0001_1111;  // M0..M4 write
  localparam logic [7:0] ELEM_RD_BG  = 8'b0001_0100;  // M2, M4 expect all-ones
  localparam logic [7:0] ELEM_WR_BG  = 8'b0000_1010;  // M1, M3 write all-ones

  // Background word of the given width: BG0 = all zeros, BG1 = all ones.
  function automatic logic [MAX_DATA_W-1:0] bg_pattern(input logic bg,
                                                       input int unsigned width);
    logic [MAX_DATA_W-1:0] ones;
    ones = '1;
    return bg ? (ones >> (MAX_DATA_W - width)) : '0;
  endfunction

endpackage

// File: rtl/bist_rd_pipe.sv
// RD_LAT-deep delay line carrying read context {valid, expected, addr, elem}.
module bist_rd_pipe
  import bist_pkg::*;
#(
  parameter int unsigned RD_LAT = 1,
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DATA_W = 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_valid,
  input  logic [DATA_W-1:0] i_exp,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [ELEM_W-1:0] i_elem,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_exp,
  output logic [ADDR_W-1:0] o_addr,
  output logic [ELEM_W-1:0] o_elem
);

  logic [RD_LAT-1:0]             r_valid;
  logic [RD_LAT-1:0][DATA_W-1:0] r_exp;
  logic [RD_LAT-1:0][ADDR_W-1:0] r_addr;
  logic [RD_LAT-1:0][ELEM_W-1:0] r_elem;

  // Shift register; reset flushes every stage so no stale compare escapes.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_valid <= '0;
      r_exp   <= '0;
      r_addr  <= '0;
      r_elem  <= '0;
    end else begin
      r_valid[0] <= i_valid;
      r_exp[0]   <= i_exp;
      r_addr[0]  <= i_addr;
      r_elem[0]  <= i_elem;
      for (int i = 1; i < RD_LAT; i++) begin
        r_valid[i] <= r_valid[i-1];
        r_exp[i]   <= r_exp[i-1];
        r_addr[i]  <= r_addr[i-1];
        r_elem[i]  <= r_elem[i-1];
      end
    end
  end

  assign o_valid = r_valid[RD_LAT-1];
  assign o_exp   = r_exp[RD_LAT-1];
  assign o_addr  = r_addr[RD_LAT-1];
  assign o_elem  = r_elem[RD_LAT-1];

endmodule

// File: rtl/bist_march_gen.sv
// March C- sequencer: drives the RAM under test and records the first miscompare.
module bist_march_gen
  import bist_pkg::*;
#(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned RD_LAT = 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  output logic [ADDR_W-1:0] o_ram_addr,
  output logic              o_ram_we,
  output logic              o_ram_re,
  output logic [DATA_W-1:0] o_ram_wdata,
  output logic [DATA_W-1:0] o_data_t,
  output logic              o_cmp_en,
  input  logic              i_eq,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_fail,
  output logic [ADDR_W-1:0] o_fail_addr,
  output logic [2:0]        o_fail_elem
);

  march_state_t      r_state, w_state_d;
  logic [ADDR_W-1:0] r_addr, w_addr_d;
  logic              r_phase, w_phase_d;  // 0: read slot, 1: write slot
  logic [2:0]        r_drain, w_drain_d;
  logic              r_fail;
  logic [ADDR_W-1:0] r_fail_addr;
  logic [2:0]        r_fail_elem;
  logic [DATA_W-1:0] r_data_t;

  logic              w_in_march, w_two_op, w_down, w_next_down;
  logic              w_rd, w_wr, w_elem_end, w_start_ok;
  logic [ELEM_W-1:0] w_elem, w_next_elem;
  logic [ADDR_W-1:0] w_last_addr;
  logic [DATA_W-1:0] w_exp_word, w_wr_word;
  logic              w_p_valid;
  logic [DATA_W-1:0] w_p_exp;
  logic [ADDR_W-1:0] w_p_addr;
  logic [ELEM_W-1:0] w_p_elem;

  // Decode the current element and the op issued this cycle.
  always_comb begin
    w_in_march  = (r_state >= StM0) && (r_state <= StM5);
    w_elem      = w_in_march ? ELEM_W'(r_state - StM0) : '0;
    w_two_op    = ELEM_HAS_RD[w_elem] & ELEM_HAS_WR[w_elem];
    w_down      = ELEM_DOWN[w_elem];
    w_rd        = w_in_march & ELEM_HAS_RD[w_elem] & (~w_two_op | ~r_phase);
    w_wr        = w_in_march & ELEM_HAS_WR[w_elem] & (~w_two_op | r_phase);
    w_last_addr = w_down ? '0 : '1;
    w_elem_end  = (r_addr == w_last_addr) & (~w_two_op | r_phase);
    w_next_elem = w_elem + ELEM_W'(1);
    w_next_down = ELEM_DOWN[w_next_elem];
    w_start_ok  = i_start & ((r_state == StIdle) | (r_state == StDone));
    w_exp_word  = DATA_W'(bg_pattern(ELEM_RD_BG[w_elem], DATA_W));
    w_wr_word   = DATA_W'(bg_pattern(ELEM_WR_BG[w_elem], DATA_W));
  end

  // Next-state: walk addresses within an element, chain elements with no gap.
  always_comb begin
    w_state_d = r_state;
    w_addr_d  = r_addr;
    w_phase_d = r_phase;
    w_drain_d = r_drain;
    case (r_state)
      StIdle, StDone: begin
        if (w_start_ok) begin
          w_state_d = StM0;
          w_addr_d  = '0;
          w_phase_d = 1'b0;
        end
      end
      StDrain: begin
        if (r_drain == 3'(RD_LAT - 1)) w_state_d = StDone;
        else                           w_drain_d = r_drain + 3'd1;
      end
      default: begin
        if (w_two_op && !r_phase) begin
          w_phase_d = 1'b1;
        end else begin
          w_phase_d = 1'b0;
          if (w_elem_end) begin
            // Element after M5 is DRAIN; its start address is don't-care.
            w_state_d = march_state_t'(r_state + 4'd1);
            w_addr_d  = w_next_down ? '1 : '0;
            w_drain_d = '0;
          end else begin
            w_addr_d = w_down ? r_addr - ADDR_W'(1) : r_addr + ADDR_W'(1);
          end
        end
      end
    endcase
  end

  // Sequencer state registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= StIdle;
      r_addr  <= '0;
      r_phase <= 1'b0;
      r_drain <= '0;
    end else begin
      r_state <= w_state_d;
      r_addr  <= w_addr_d;
      r_phase <= w_phase_d;
      r_drain <= w_drain_d;
    end
  end

  // Fail capture (first miscompare wins) and data_t hold between compares.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_fail      <= 1'b0;
      r_fail_addr <= '0;
      r_fail_elem <= '0;
      r_data_t    <= '0;
    end else begin
      if (w_p_valid) r_data_t <= w_p_exp;
      if (w_start_ok) begin
        r_fail      <= 1'b0;
        r_fail_addr <= '0;
        r_fail_elem <= '0;
      end else if (w_p_valid && !i_eq) begin
        r_fail <= 1'b1;
        if (!r_fail) begin
          r_fail_addr <= w_p_addr;
          r_fail_elem <= w_p_elem;
        end
      end
    end
  end

  bist_rd_pipe #(
    .RD_LAT(RD_LAT),
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_rd_pipe (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_valid(w_rd),
    .i_exp  (w_exp_word),
    .i_addr (r_addr),
    .i_elem (w_elem),
    .o_valid(w_p_valid),
    .o_exp  (w_p_exp),
    .o_addr (w_p_addr),
    .o_elem (w_p_elem)
  );

  assign o_ram_addr  = (w_rd | w_wr) ? r_addr : '0;
  assign o_ram_we    = w_wr;
  assign o_ram_re    = w_rd;
  assign o_ram_wdata = w_wr ? w_wr_word : '0;
  assign o_cmp_en    = w_p_valid;
  assign o_data_t    = w_p_valid ? w_p_exp : r_data_t;
  assign o_busy      = w_in_march | (r_state == StDrain);
  assign o_done      = (r_state == StDone);
  assign o_fail      = r_fail;
  assign o_fail_addr = r_fail_addr;
  assign o_fail_elem = r_fail_elem;

endmodule

// File: tb/tb_bist_march_gen.sv
// Bench for bist_march_gen: reference March C- trace plus a compare scoreboard.
module tb_bist_march_gen;

  localparam int D = 16;

  typedef struct packed {
    logic       we;
    logic       re;
    logic [3:0] addr;
    logic [7:0] data;
  } op_t;

  typedef struct packed {
    int         cyc;
    logic [7:0] data;
  } cmp_t;

  logic clk, rst, start, sel, flt;
  int   n_checks, n_err;
  op_t  q_op[$];
  cmp_t q_cmp[$];

  // DUT 1 (RD_LAT=1) and DUT 2 (RD_LAT=2) share start/rst.
  logic [3:0] addr1, addr2, faddr1, faddr2;
  logic       we1, re1, cmp1, busy1, done1, fail1, eq1;
  logic       we2, re2, cmp2, busy2, done2, fail2, eq2;
  logic [7:0] wd1, dt1, wd2, dt2;
  logic [2:0] felem1, felem2;

  bist_march_gen #(.ADDR_W(4), .DATA_W(8), .RD_LAT(1)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .o_ram_addr(addr1), .o_ram_we(we1),
    .o_ram_re(re1), .o_ram_wdata(wd1), .o_data_t(dt1), .o_cmp_en(cmp1), .i_eq(eq1),
    .o_busy(busy1), .o_done(done1), .o_fail(fail1), .o_fail_addr(faddr1),
    .o_fail_elem(felem1)
  );

  bist_march_gen #(.ADDR_W(4), .DATA_W(8), .RD_LAT(2)) dut2 (
    .i_clk(clk), .i_rst(rst), .i_start(start), .o_ram_addr(addr2), .o_ram_we(we2),
    .o_ram_re(re2), .o_ram_wdata(wd2), .o_data_t(dt2), .o_cmp_en(cmp2), .i_eq(eq2),
    .o_busy(busy2), .o_done(done2), .o_fail(fail2), .o_fail_addr(faddr2),
    .o_fail_elem(felem2)
  );

  // Behavioural RAMs with optional bit0 stuck-at-1 at address 5, plus comparators.
  logic [7:0] mem1[16];
  logic [7:0] mem2[16];
  logic [7:0] rp1, rp2a, rp2b;

  always @(posedge clk) begin
    if (we1) mem1[addr1] <= wd1;
    rp1 <= mem1[addr1] | ((flt && addr1 == 4'd5) ? 8'h01 : 8'h00);
    if (we2) mem2[addr2] <= wd2;
    rp2a <= mem2[addr2] | ((flt && addr2 == 4'd5) ? 8'h01 : 8'h00);
    rp2b <= rp2a;
  end

  assign eq1 = (rp1 === dt1);
  assign eq2 = (rp2b === dt2);

  // Observed signals of the DUT under test.
  logic [3:0] s_addr, s_faddr;
  logic       s_we, s_re, s_cmp, s_busy, s_done, s_fail;
  logic [7:0] s_wd, s_dt;
  logic [2:0] s_felem;

  always_comb begin
    s_addr  = sel ? addr2 : addr1;
    s_we    = sel ? we2 : we1;
    s_re    = sel ? re2 : re1;
    s_wd    = sel ? wd2 : wd1;
    s_dt    = sel ? dt2 : dt1;
    s_cmp   = sel ? cmp2 : cmp1;
    s_busy  = sel ? busy2 : busy1;
    s_done  = sel ? done2 : done1;
    s_fail  = sel ? fail2 : fail1;
    s_faddr = sel ? faddr2 : faddr1;
    s_felem = sel ? felem2 : felem1;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Reference March C- op sequence for D words.
  task automatic build_trace();
    q_op.delete();
    for (int a = 0; a < D; a++) q_op.push_back('{1'b1, 1'b0, 4'(a), 8'h00});
    for (int a = 0; a < D; a++) begin
      q_op.push_back('{1'b0, 1'b1, 4'(a), 8'h00});
      q_op.push_back('{1'b1, 1'b0, 4'(a), 8'hFF});
    end
    for (int a = 0; a < D; a++) begin
      q_op.push_back('{1'b0, 1'b1, 4'(a), 8'hFF});
      q_op.push_back('{1'b1, 1'b0, 4'(a), 8'h00});
    end
    for (int a = D - 1; a >= 0; a--) begin
      q_op.push_back('{1'b0, 1'b1, 4'(a), 8'h00});
      q_op.push_back('{1'b1, 1'b0, 4'(a), 8'hFF});
    end
    for (int a = D - 1; a >= 0; a--) begin
      q_op.push_back('{1'b0, 1'b1, 4'(a), 8'hFF});
      q_op.push_back('{1'b1, 1'b0, 4'(a), 8'h00});
    end
    for (int a = 0; a < D; a++) q_op.push_back('{1'b0, 1'b1, 4'(a), 8'h00});
  endtask

  // One run: start sampled at edge 0, cycle c is observed after edge c-1.
  task automatic run_test(input logic s, input int lat, input logic fault,
                          input int repulse_at, input int rst_at);
    op_t  e;
    cmp_t c;
    logic ec, aborted;
    int   n_cmp;
    sel = s;
    flt = fault;
    aborted = 1'b0;
    n_cmp = 0;
    build_trace();
    q_cmp.delete();
    @(negedge clk);
    start = 1'b1;
    for (int cyc = 1; cyc <= 10 * D + lat + 3; cyc++) begin
      @(negedge clk);
      if (!aborted && q_op.size() > 0) e = q_op.pop_front();
      else e = '0;
      chk("op", {s_we, s_re, (e.we | e.re) ? s_addr : 4'h0, e.we ? s_wd : 8'h00},
          {e.we, e.re, (e.we | e.re) ? e.addr : 4'h0, e.we ? e.data : 8'h00});
      if (e.re) q_cmp.push_back('{cyc + lat, e.data});
      ec = (q_cmp.size() > 0) && (q_cmp[0].cyc == cyc);
      chk("cmp_en", s_cmp, ec);
      if (ec) begin
        c = q_cmp.pop_front();
        n_cmp++;
        chk("data_t", s_dt, c.data);
      end
      if (cyc == 1) chk("run_start", {s_busy, s_done, s_fail}, 3'b100);
      if (fault && cyc == 27 + lat) chk("fail_pre_m1", s_fail, 1'b0);
      if (fault && cyc == 28 + lat)
        chk("fail_m1", {s_fail, s_faddr, s_felem}, {1'b1, 4'd5, 3'd1});
      if (!aborted && cyc == 10 * D + lat) chk("pre_done", {s_busy, s_done}, 2'b10);
      if (!aborted && cyc == 10 * D + lat + 1) begin
        chk("done", {s_busy, s_done}, 2'b01);
        chk("fail_end", {s_fail, s_faddr, s_felem}, fault ? {1'b1, 4'd5, 3'd1} : 8'd0);
        chk("n_cmp", n_cmp, 80);
      end
      if (aborted && cyc == rst_at + 1)
        chk("rst_zero", {s_we, s_re, s_addr, s_wd, s_dt, s_cmp, s_busy, s_done, s_fail,
                         s_faddr, s_felem}, '0);
      start = (cyc == repulse_at);
      rst   = (cyc == rst_at);
      if (cyc == rst_at) begin
        aborted = 1'b1;
        q_op.delete();
        q_cmp.delete();
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_err    = 0;
    rst      = 1'b1;
    start    = 1'b0;
    sel      = 1'b0;
    flt      = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset", {s_we, s_re, s_addr, s_wd, s_dt, s_cmp, s_busy, s_done, s_fail, s_faddr,
                  s_felem}, '0);
    rst = 1'b0;
    run_test(1'b0, 1, 1'b0, 0, 0);   // clean run
    run_test(1'b0, 1, 1'b1, 0, 0);   // stuck-at fault at addr 5
    run_test(1'b0, 1, 1'b0, 0, 0);   // restart from DONE clears fail
    run_test(1'b0, 1, 1'b0, 0, 90);  // reset during M3
    run_test(1'b0, 1, 1'b0, 0, 0);   // clean run after reset
    run_test(1'b0, 1, 1'b0, 55, 0);  // start re-pulsed during M2
    run_test(1'b1, 2, 1'b0, 0, 0);   // RD_LAT=2
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
